ibex_prefetch_buffer_nreq: RTL and testbench
============================================

Name: ibex_prefetch_buffer_nreq

Overview:
- Parametrised successor of the core's instruction prefetch buffer.
- Issues sequential word-aligned fetches after each branch and keeps up to NumReqs requests outstanding on the req/gnt/rvalid instruction bus.
- Buffers returned words in an internal FIFO of FifoDepth entries.
- Adds over the previous generation: a runtime outstanding cap, counter-based discard tracking, halt-on-bus-error, and an outstanding-count status output.

Parameters:
- NumReqs, 4, maximum outstanding granted requests; legal range 1..8.
- FifoDepth, 5, fetch FIFO entries; must be at least NumReqs+1.
- CntW, $clog2(NumReqs+1), width of count signals; derived, never overridden.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_i  in  1  core wants instructions
- branch_i  in  1  redirect to addr_i; flushes FIFO and discards in-flight data
- addr_i  in  32  branch target; bits [1:0] ignored
- max_outstanding_i  in  CntW  runtime outstanding cap; 0 or >NumReqs means NumReqs
- ready_i  in  1  consumer accepts head word
- valid_o  out  1  head word valid
- rdata_o  out  32  head word data
- addr_o  out  32  head word address, word-aligned
- err_o  out  1  head word bus error
- instr_req_o  out  1  bus request
- instr_gnt_i  in  1  bus grant
- instr_addr_o  out  32  bus address, bits [1:0]=0
- instr_rdata_i  in  32  bus read data
- instr_err_i  in  1  bus error with rvalid
- instr_rvalid_i  in  1  bus response valid
- busy_o  out  1  cnt_q!=0 or instr_req_o
- outstanding_o  out  CntW  cnt_q

Behaviour:
- Reset (rst_i high at clk_i edge), all cleared:
  - cnt_q, disc_q, FIFO count, valid_req_q, discard_req_q, halt_q all 0.
  - Outputs valid_o, instr_req_o, busy_o, err_o all 0; outstanding_o = 0.
  - Data and address registers are not reset.
- Request issue:
  - new_req = req_i & (~halt_q | branch_i) & cnt_q<cap & space_ok.
  - space_ok = branch_i ? 1 : (cnt_q + fifo_cnt < FifoDepth).
  - Bus request: instr_req_o = valid_req_q | new_req. A request is held with a stable address until instr_gnt_i.
  - valid_req_q <= instr_req_o & ~instr_gnt_i.
- Address:
  - Address mux: valid_req_q ? stored_addr_q : branch_i ? {addr_i[31:2],2'b00} : fetch_addr_q.
  - fetch_addr_q loads addr_i on branch.
  - fetch_addr_q advances by 4 for every new (not held) request; it wraps modulo 2^32.
- Outstanding counter:
  - cnt_d = cnt_q + (instr_req_o & instr_gnt_i) - (instr_rvalid_i & cnt_q!=0).
  - cnt_q never exceeds NumReqs.
- Discard counter:
  - On branch_i: disc_d = cnt_q - (rvalid & cnt_q!=0) + (valid_req_q & instr_gnt_i).
  - Otherwise: disc_d = disc_q - (rvalid & disc_q!=0) + (valid_req_q & gnt & discard_req_q).
  - discard_req_q <= valid_req_q & ~instr_gnt_i & (branch_i | discard_req_q); it marks a held pre-branch request.
  - A request newly issued in the branch cycle (addr_i) is never discarded.
- Response handling:
  - push = instr_rvalid_i & cnt_q!=0 & disc_q==0.
  - rvalid with disc_q!=0 is dropped.
  - rvalid with cnt_q==0 (e.g. after reset mid-transaction) is dropped and counters are unchanged.
- FIFO:
  - Synchronous, FifoDepth entries of {rdata, addr, err}.
  - Push address is tracked by a separate head-address counter: it loads on branch, increments on every push, and is written with each entry.
  - valid_o = FIFO not empty. Latency from rvalid to valid_o is 1 cycle.
  - pop = valid_o & ready_i.
  - Simultaneous push and pop keeps the count.
  - branch_i empties the FIFO in the same cycle; pop and push in that cycle are ignored.
  - Overflow is impossible by construction; flag it with an assertion.
- Halt:
  - halt_q sets when an entry with instr_err_i=1 is pushed.
  - While halt_q is set, no new requests issue; a held request still completes; words still drain.
  - halt_q clears on branch_i. Branch wins over a simultaneous error push.
- Cap:
  - cap = (max_outstanding_i==0 | max_outstanding_i>NumReqs) ? NumReqs : max_outstanding_i.
  - Lowering the cap below cnt_q stops issue only; nothing is cancelled.

Test Plan:
- Reset, branch to 0x1000, req_i=1, gnt always 1, rvalid 2 cycles after grant, ready_i=1 -> instr_addr_o 0x1000, 0x1004, 0x1008…; addr_o matches in order; outstanding_o settles at 2.
- NumReqs=4, gnt=1, rvalid withheld -> exactly 4 grants; outstanding_o=4; instr_req_o low; 4 rvalids then return cnt to 0.
- 3 outstanding, branch to 0x2002 -> 3 following rvalids dropped; first pushed word has addr_o=0x2000; FIFO empty in branch cycle.
- Request held ungranted at 0x3008 during branch to 0x4000 -> that grant is later discarded, and the next issued address is 0x4000.
- ready_i=0, gnt=1, zero-latency responses -> FIFO fills to 5; cnt+fifo never exceeds 5; no overflow assertion fires.
- Response with instr_err_i=1 at 0x5004 -> err_o=1 on that word; no further requests; branch to 0x6000 resumes fetching.

Source files
------------

// File: rtl/ibex_prefetch_buffer_nreq.sv
// Instruction prefetch buffer: sequential fetches after each branch, up to NumReqs requests
// in flight on the req/gnt/rvalid bus, returned words queued in a FifoDepth-entry FIFO.
module ibex_prefetch_buffer_nreq #(
   parameter int unsigned NumReqs   = 4,
   parameter int unsigned FifoDepth = 5,
   parameter int unsigned CntW      = $clog2(NumReqs + 1)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            req_i,
   input  logic            branch_i,
   input  logic [31:0]     addr_i,
   input  logic [CntW-1:0] max_outstanding_i,
   input  logic            ready_i,
   output logic            valid_o,
   output logic [31:0]     rdata_o,
   output logic [31:0]     addr_o,
   output logic            err_o,
   output logic            instr_req_o,
   input  logic            instr_gnt_i,
   output logic [31:0]     instr_addr_o,
   input  logic [31:0]     instr_rdata_i,
   input  logic            instr_err_i,
   input  logic            instr_rvalid_i,
   output logic            busy_o,
   output logic [CntW-1:0] outstanding_o
);

   localparam int unsigned FCntW = $clog2(FifoDepth + 1);
   localparam int unsigned PtrW  = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
   localparam int unsigned SumW  = ((CntW > FCntW) ? CntW : FCntW) + 1;

   localparam logic [CntW-1:0]  NumReqsC = CntW'(NumReqs);
   localparam logic [SumW-1:0]  DepthS   = SumW'(FifoDepth);
   localparam logic [FCntW-1:0] DepthF   = FCntW'(FifoDepth);
   localparam logic [PtrW-1:0]  LastPtr  = PtrW'(FifoDepth - 1);

   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [CntW-1:0]  disc_q, disc_d;
   logic [FCntW-1:0] fifo_cnt_q, fifo_cnt_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic             valid_req_q, valid_req_d;
   logic             discard_req_q, discard_req_d;
   logic             halt_q, halt_d;
   logic [31:0]      fetch_addr_q, fetch_addr_d;
   logic [31:0]      stored_addr_q, stored_addr_d;
   logic [31:0]      head_addr_q, head_addr_d;

   logic [31:0] rdata_mem [FifoDepth];
   logic [31:0] addr_mem  [FifoDepth];
   logic        err_mem   [FifoDepth];

   logic [CntW-1:0] cap;
   logic [SumW-1:0] occupancy;
   logic [31:0]     branch_addr;
   logic            space_ok;
   logic            new_req;
   logic            granted;
   logic            rvalid_ok;
   logic            push;
   logic            pop;
   logic            unused_addr;

   assign unused_addr = ^addr_i[1:0];
   assign branch_addr = {addr_i[31:2], 2'b00};

   always_comb begin
      cap = max_outstanding_i;
      if ((max_outstanding_i == '0) || (max_outstanding_i > NumReqsC)) begin
         cap = NumReqsC;
      end
   end

   // Discarded in-flight words still count toward occupancy, keeping the check conservative.
   assign occupancy = SumW'(cnt_q) + SumW'(fifo_cnt_q);
   assign space_ok  = branch_i | (occupancy < DepthS);
   assign new_req   = req_i & (~halt_q | branch_i) & (cnt_q < cap) & space_ok;

   assign instr_req_o  = valid_req_q | new_req;
   assign instr_addr_o = valid_req_q ? stored_addr_q :
                         branch_i    ? branch_addr   : fetch_addr_q;

   assign granted   = instr_req_o & instr_gnt_i;
   assign rvalid_ok = instr_rvalid_i & (cnt_q != '0);
   assign push      = rvalid_ok & (disc_q == '0) & ~branch_i;
   assign pop       = valid_o & ready_i & ~branch_i;

   always_comb begin
      cnt_d         = cnt_q + CntW'(granted) - CntW'(rvalid_ok);
      valid_req_d   = instr_req_o & ~instr_gnt_i;
      discard_req_d = valid_req_q & ~instr_gnt_i & (branch_i | discard_req_q);
      if (branch_i) begin
         // Everything granted so far belongs to the old stream, including a held request.
         disc_d = cnt_q - CntW'(rvalid_ok) + CntW'(valid_req_q & instr_gnt_i);
      end else begin
         disc_d = disc_q - CntW'(instr_rvalid_i & (disc_q != '0))
                         + CntW'(valid_req_q & instr_gnt_i & discard_req_q);
      end
   end

   always_comb begin
      halt_d = halt_q;
      if (branch_i) begin
         halt_d = 1'b0;
      end else if (push && instr_err_i) begin
         halt_d = 1'b1;
      end
   end

   always_comb begin
      fetch_addr_d  = fetch_addr_q;
      stored_addr_d = stored_addr_q;
      head_addr_d   = head_addr_q;
      if (branch_i) begin
         fetch_addr_d = branch_addr;
         head_addr_d  = branch_addr;
      end else if (push) begin
         head_addr_d = head_addr_q + 32'd4;
      end
      if (new_req && !valid_req_q) begin
         fetch_addr_d  = instr_addr_o + 32'd4;
         stored_addr_d = instr_addr_o;
      end
   end

   always_comb begin
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      fifo_cnt_d = fifo_cnt_q;
      if (branch_i) begin
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         fifo_cnt_d = '0;
      end else begin
         if (push) begin
            wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
         end
         if (pop) begin
            rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
         end
         fifo_cnt_d = fifo_cnt_q + FCntW'(push) - FCntW'(pop);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q         <= '0;
         disc_q        <= '0;
         fifo_cnt_q    <= '0;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         valid_req_q   <= 1'b0;
         discard_req_q <= 1'b0;
         halt_q        <= 1'b0;
      end else begin
         cnt_q         <= cnt_d;
         disc_q        <= disc_d;
         fifo_cnt_q    <= fifo_cnt_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         valid_req_q   <= valid_req_d;
         discard_req_q <= discard_req_d;
         halt_q        <= halt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      fetch_addr_q  <= fetch_addr_d;
      stored_addr_q <= stored_addr_d;
      head_addr_q   <= head_addr_d;
      if (push) begin
         rdata_mem[wr_ptr_q] <= instr_rdata_i;
         addr_mem[wr_ptr_q]  <= head_addr_q;
         err_mem[wr_ptr_q]   <= instr_err_i;
      end
   end

   assign valid_o       = (fifo_cnt_q != '0);
   assign rdata_o       = rdata_mem[rd_ptr_q];
   assign addr_o        = addr_mem[rd_ptr_q];
   assign err_o         = valid_o & err_mem[rd_ptr_q];
   assign busy_o        = (cnt_q != '0) | instr_req_o;
   assign outstanding_o = cnt_q;

   a_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i)
      !(push && !pop && (fifo_cnt_q == DepthF)));

   a_cnt_bound : assert property (@(posedge clk_i) disable iff (rst_i)
      cnt_q <= NumReqsC);

endmodule

// File: tb/tb_ibex_prefetch_buffer_nreq.sv
// Bench for ibex_prefetch_buffer_nreq: hand-derived vector table, directed corner sequences and
// random traffic checked against a queue-based model of the fetch stream.
module tb_ibex_prefetch_buffer_nreq;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        req_i = 1'b0;
   logic        branch_i = 1'b0;
   logic [31:0] addr_i = '0;
   logic [2:0]  max_outstanding_i = '0;
   logic        ready_i = 1'b0;
   logic        valid_o;
   logic [31:0] rdata_o;
   logic [31:0] addr_o;
   logic        err_o;
   logic        instr_req_o;
   logic        instr_gnt_i = 1'b0;
   logic [31:0] instr_addr_o;
   logic [31:0] instr_rdata_i = '0;
   logic        instr_err_i = 1'b0;
   logic        instr_rvalid_i = 1'b0;
   logic        busy_o;
   logic [2:0]  outstanding_o;

   always #5 clk_i = ~clk_i;

   ibex_prefetch_buffer_nreq #(
      .NumReqs  (4),
      .FifoDepth(5)
   ) dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .req_i            (req_i),
      .branch_i         (branch_i),
      .addr_i           (addr_i),
      .max_outstanding_i(max_outstanding_i),
      .ready_i          (ready_i),
      .valid_o          (valid_o),
      .rdata_o          (rdata_o),
      .addr_o           (addr_o),
      .err_o            (err_o),
      .instr_req_o      (instr_req_o),
      .instr_gnt_i      (instr_gnt_i),
      .instr_addr_o     (instr_addr_o),
      .instr_rdata_i    (instr_rdata_i),
      .instr_err_i      (instr_err_i),
      .instr_rvalid_i   (instr_rvalid_i),
      .busy_o           (busy_o),
      .outstanding_o    (outstanding_o)
   );

   // Model: granted bus transactions in order, and the words the consumer should see.
   typedef struct {
      logic [31:0] addr;
      bit          disc;
   } txn_t;
   typedef struct {
      logic [31:0] data;
      logic [31:0] addr;
      bit          err;
   } ent_t;

   txn_t        bus_q[$];
   ent_t        fq[$];
   bit          held = 0;
   bit          held_disc = 0;
   logic [31:0] held_addr = '0;
   bit          halt = 0;
   bit          addr_known = 0;
   logic [31:0] next_addr = '0;
   logic [2:0]  max_r = '0;
   bit          exp_req;
   logic [31:0] exp_addr;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      bit          rst, req, br;
      logic [31:0] a;
      bit          gnt, rv, rdy;
      bit          chk;
      bit          e_req;
      logic [31:0] e_iaddr;
      bit          e_valid;
      logic [31:0] e_addr;
      int          e_out;
   } vec_t;

   vec_t tbl[12];

   function automatic logic [31:0] data_of(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Apply inputs mid-cycle, then compare combinational/registered outputs against the model.
   task automatic drive(input bit rst, input bit req, input bit br, input logic [31:0] a,
                        input bit gnt, input bit rv, input bit er, input bit rdy);
      int cnt;
      int cap;
      rst_i             = rst;
      req_i             = req;
      branch_i          = br;
      addr_i            = a;
      instr_gnt_i       = gnt;
      instr_rvalid_i    = rv;
      instr_err_i       = er;
      ready_i           = rdy;
      max_outstanding_i = max_r;
      instr_rdata_i     = (bus_q.size() != 0) ? data_of(bus_q[0].addr) : 32'hDEAD_BEEF;
      #1;
      cnt = bus_q.size();
      cap = (max_r == 0 || max_r > 4) ? 4 : int'(max_r);
      exp_req  = held || (req && (!halt || br) && cnt < cap && (br || cnt + fq.size() < 5));
      exp_addr = held ? held_addr : br ? {a[31:2], 2'b00} : next_addr;
      if (!rst) begin
         chk("instr_req", {31'd0, instr_req_o}, {31'd0, exp_req});
         if (exp_req && (held || br || addr_known)) chk("instr_addr", instr_addr_o, exp_addr);
         chk("valid", {31'd0, valid_o}, {31'd0, fq.size() != 0});
         if (fq.size() != 0) begin
            chk("rdata", rdata_o, fq[0].data);
            chk("addr_o", addr_o, fq[0].addr);
            chk("err", {31'd0, err_o}, {31'd0, fq[0].err});
         end
         chk("outstanding", {29'd0, outstanding_o}, cnt);
         chk("busy", {31'd0, busy_o}, {31'd0, (cnt != 0) || exp_req});
         chk("occupancy", {31'd0, (int'(outstanding_o) + fq.size()) <= 5}, 32'd1);
      end
   endtask

   task automatic step();
      txn_t t;
      bit   new_held;
      if (rst_i) begin
         bus_q.delete();
         fq.delete();
         held       = 0;
         held_disc  = 0;
         halt       = 0;
         addr_known = 0;
      end else begin
         if (fq.size() != 0 && ready_i && !branch_i) void'(fq.pop_front());
         if (instr_rvalid_i && bus_q.size() != 0) begin
            t = bus_q.pop_front();
            if (!t.disc && !branch_i) begin
               fq.push_back('{data_of(t.addr), t.addr, instr_err_i});
               if (instr_err_i) halt = 1;
            end
         end
         if (branch_i) begin
            foreach (bus_q[i]) bus_q[i].disc = 1;
            fq.delete();
            halt       = 0;
            next_addr  = {addr_i[31:2], 2'b00};
            addr_known = 1;
            if (held) held_disc = 1;
         end
         if (exp_req && !held) next_addr = exp_addr + 32'd4;
         if (exp_req && instr_gnt_i) bus_q.push_back('{exp_addr, held ? held_disc : 1'b0});
         new_held = exp_req && !instr_gnt_i;
         if (new_held && !held) begin
            held_addr = exp_addr;
            held_disc = 0;
         end
         held = new_held;
      end
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   task automatic cyc(input bit rst, input bit req, input bit br, input logic [31:0] a,
                      input bit gnt, input bit rv, input bit er, input bit rdy);
      drive(rst, req, br, a, gnt, rv, er, rdy);
      step();
   endtask

   initial begin
      int          grants;
      int          pops;
      bit          saw_err;
      bit          seen;
      logic [31:0] first_addr;
      bit          r, b, need_br, rq, g, v, e, rd;
      logic [31:0] a;

      // rst req br addr gnt rv rdy | chk e_req e_iaddr e_valid e_addr e_out
      tbl[0]  = '{1, 0, 0, 32'h0,    0, 0, 1, 0, 0, 32'h0,    0, 32'h0,    0};
      tbl[1]  = '{0, 0, 0, 32'h0,    0, 0, 1, 1, 0, 32'h0,    0, 32'h0,    0};
      tbl[2]  = '{0, 1, 1, 32'h1000, 1, 0, 1, 1, 1, 32'h1000, 0, 32'h0,    0};
      tbl[3]  = '{0, 1, 0, 32'h0,    1, 0, 1, 1, 1, 32'h1004, 0, 32'h0,    1};
      tbl[4]  = '{0, 1, 0, 32'h0,    1, 0, 1, 1, 1, 32'h1008, 0, 32'h0,    2};
      tbl[5]  = '{0, 1, 1, 32'h2002, 0, 0, 1, 1, 1, 32'h2000, 0, 32'h0,    3};
      tbl[6]  = '{0, 1, 0, 32'h0,    0, 1, 1, 1, 1, 32'h2000, 0, 32'h0,    3};
      tbl[7]  = '{0, 1, 0, 32'h0,    1, 1, 1, 1, 1, 32'h2000, 0, 32'h0,    2};
      tbl[8]  = '{0, 0, 0, 32'h0,    0, 1, 1, 1, 0, 32'h0,    0, 32'h0,    2};
      tbl[9]  = '{0, 0, 0, 32'h0,    0, 1, 1, 1, 0, 32'h0,    0, 32'h0,    1};
      tbl[10] = '{0, 0, 0, 32'h0,    0, 0, 1, 1, 0, 32'h0,    1, 32'h2000, 0};
      tbl[11] = '{0, 0, 0, 32'h0,    0, 0, 1, 1, 0, 32'h0,    0, 32'h0,    0};

      @(negedge clk_i);
      foreach (tbl[i]) begin
         drive(tbl[i].rst, tbl[i].req, tbl[i].br, tbl[i].a, tbl[i].gnt, tbl[i].rv, 0, tbl[i].rdy);
         if (tbl[i].chk) begin
            chk("tbl_req", {31'd0, instr_req_o}, {31'd0, tbl[i].e_req});
            if (tbl[i].e_req) chk("tbl_iaddr", instr_addr_o, tbl[i].e_iaddr);
            chk("tbl_valid", {31'd0, valid_o}, {31'd0, tbl[i].e_valid});
            if (tbl[i].e_valid) chk("tbl_addr_o", addr_o, tbl[i].e_addr);
            chk("tbl_out", {29'd0, outstanding_o}, tbl[i].e_out);
         end
         step();
      end

      // Outstanding limit at NumReqs with responses withheld, then drained.
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      grants = 0;
      for (int i = 0; i < 8; i++) begin
         drive(0, 1, i == 0, 32'h8000, 1, 0, 0, 1);
         if (instr_req_o && instr_gnt_i) grants++;
         step();
      end
      drive(0, 1, 0, 0, 1, 0, 0, 1);
      chk("cap_grants", grants, 4);
      chk("cap_out", {29'd0, outstanding_o}, 4);
      chk("cap_req_low", {31'd0, instr_req_o}, 0);
      step();
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 1, 0, 1);
      drive(0, 0, 0, 0, 0, 0, 0, 1);
      chk("cap_drained", {29'd0, outstanding_o}, 0);
      step();
      for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0, 0, 0, 1);

      // Runtime cap of 2, then reset with responses still in flight.
      max_r = 3'd2;
      cyc(0, 1, 1, 32'h9000, 1, 0, 0, 1);
      for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 1, 0, 0, 1);
      drive(0, 1, 0, 0, 1, 0, 0, 1);
      chk("cap2_out", {29'd0, outstanding_o}, 2);
      step();
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 1, 0, 1);
      drive(0, 0, 0, 0, 0, 1, 0, 1);
      chk("stray_rvalid_out", {29'd0, outstanding_o}, 0);
      chk("stray_rvalid_valid", {31'd0, valid_o}, 0);
      step();
      max_r = 3'd7;

      // Request held ungranted across a branch: its grant is discarded.
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 1, 1, 32'h3000, 1, 0, 0, 1);
      cyc(0, 1, 0, 0, 1, 0, 0, 1);
      cyc(0, 1, 0, 0, 0, 0, 0, 1);
      drive(0, 1, 1, 32'h4000, 0, 0, 0, 1);
      chk("held_addr", instr_addr_o, 32'h3008);
      step();
      cyc(0, 1, 0, 0, 1, 0, 0, 1);
      drive(0, 1, 0, 0, 1, 0, 0, 1);
      chk("post_branch_addr", instr_addr_o, 32'h4000);
      step();
      seen = 0;
      first_addr = '0;
      for (int i = 0; i < 10; i++) begin
         drive(0, 0, 0, 0, 0, 1, 0, 1);
         if (valid_o && !seen) begin
            seen = 1;
            first_addr = addr_o;
         end
         step();
      end
      chk("held_first_word", first_addr, 32'h4000);

      // FIFO fills with the consumer stalled, then drains.
      max_r = 3'd0;
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 1, 1, 32'h7000, 1, 0, 0, 0);
      for (int i = 0; i < 14; i++) cyc(0, 1, 0, 0, 1, bus_q.size() != 0, 0, 0);
      drive(0, 1, 0, 0, 1, 0, 0, 0);
      chk("full_req_low", {31'd0, instr_req_o}, 0);
      chk("full_out", {29'd0, outstanding_o}, 0);
      step();
      pops = 0;
      for (int i = 0; i < 8; i++) begin
         drive(0, 0, 0, 0, 0, 0, 0, 1);
         if (valid_o) pops++;
         step();
      end
      chk("full_pops", pops, 5);

      // Bus error halts fetching until the next branch.
      cyc(1, 0, 0, 0, 0, 0, 0, 0);
      cyc(0, 1, 1, 32'h5000, 1, 0, 0, 1);
      saw_err = 0;
      for (int i = 0; i < 12; i++) begin
         v = bus_q.size() != 0;
         e = v && (bus_q[0].addr == 32'h5004);
         drive(0, 1, 0, 0, 1, v, e, 1);
         if (valid_o && err_o && addr_o == 32'h5004) saw_err = 1;
         step();
      end
      drive(0, 1, 0, 0, 1, 0, 0, 1);
      chk("err_seen", {31'd0, saw_err}, 1);
      chk("halt_req_low", {31'd0, instr_req_o}, 0);
      step();
      drive(0, 1, 1, 32'h6000, 1, 0, 0, 1);
      chk("resume_req", {31'd0, instr_req_o}, 1);
      chk("resume_addr", instr_addr_o, 32'h6000);
      step();

      // Random traffic against the model.
      need_br = 0;
      for (int i = 0; i < 3000; i++) begin
         r  = ($urandom_range(0, 399) == 0);
         b  = need_br || ($urandom_range(0, 15) == 0);
         a  = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                          : $urandom;
         rq = ($urandom_range(0, 7) != 0);
         g  = ($urandom_range(0, 2) != 0);
         v  = ($urandom_range(0, 1) != 0);
         e  = ($urandom_range(0, 15) == 0);
         rd = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 63) == 0) max_r = 3'($urandom_range(0, 7));
         if (r) begin
            cyc(1, 0, 0, 0, 0, 0, 0, 0);
            need_br = 1;
         end else begin
            cyc(0, rq, b, a, g, v, e, rd);
            if (b) need_br = 0;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
